// File: rtl/vending_change_fsm.sv
// vending_change_fsm
//
// Coin-operated vending controller. Credit from nickel/dime (and, when
// VEND_QUARTER_EN is defined, quarter) strobes accumulates toward PRICE. On
// reaching the price the item is vended for one cycle. Any overpayment is then
// paid back as back-to-back dime pulses followed by at most one nickel pulse.
// A cancel in IDLE with non-zero credit refunds the whole credit the same way,
// without vending.
//
// Build option:
//   VEND_QUARTER_EN  defined   -> quarter is a valid 25-cent coin
//                    undefined -> quarter is always rejected (port kept)
//
// Parameters:
//   PRICE     item price in cents, multiple of 5, 5..(2**CREDIT_W - 30)
//   CREDIT_W  width of the credit register
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   nickel       5-cent coin strobe (one-cycle pulse per coin)
//   dime         10-cent coin strobe
//   quarter      25-cent coin strobe (credited only with VEND_QUARTER_EN)
//   cancel       refund request, honoured only in IDLE
//   vend         dispense pulse, high while in VEND
//   dime_out     return one dime this cycle
//   nickel_out   return one nickel this cycle
//   coin_reject  one-cycle pulse: the coin(s) sampled last edge were not credited
//   busy         high in VEND or CHANGE
//   credit       current credit in cents
//   state_out    IDLE = 00, VEND = 01, CHANGE = 10

module vending_change_fsm #(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                vend,
  output logic                dime_out,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state_out
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StVend   = 2'b01,
    StChange = 2'b10
  } state_e;

`ifdef VEND_QUARTER_EN
  localparam bit QuarterEn = 1'b1;
`else
  localparam bit QuarterEn = 1'b0;
`endif

  localparam logic [CREDIT_W-1:0] Zero        = '0;
  localparam logic [CREDIT_W-1:0] NickelValue = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DimeValue   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QuarterVal  = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] PriceValue  = CREDIT_W'(PRICE);

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  coin_reject_q, coin_reject_d;

  // Coin decode
  logic                  any_strobe;
  logic                  coin_valid;
  logic [CREDIT_W-1:0]   coin_value;
  logic [CREDIT_W-1:0]   credit_sum;

  // Change payout
  logic                  give_dime;
  logic [CREDIT_W-1:0]   change_left;

  // Exactly one enabled strobe makes a valid coin; any other non-zero
  // combination (including a lone quarter when quarters are disabled) is rejected.
  always_comb begin
    any_strobe = nickel | dime | quarter;
    coin_valid = 1'b0;
    coin_value = Zero;
    case ({quarter, dime, nickel})
      3'b001: begin
        coin_valid = 1'b1;
        coin_value = NickelValue;
      end
      3'b010: begin
        coin_valid = 1'b1;
        coin_value = DimeValue;
      end
      3'b100: begin
        coin_valid = QuarterEn;
        coin_value = QuarterEn ? QuarterVal : Zero;
      end
      default: begin
        coin_valid = 1'b0;
        coin_value = Zero;
      end
    endcase
  end

  // Credit never exceeds PRICE + 20 inside the legal parameter range, so the
  // CREDIT_W-bit sum cannot wrap.
  assign credit_sum = credit_q + coin_value;

  // Largest coin first: dimes while at least 10 cents remain, then one nickel.
  always_comb begin
    give_dime   = (credit_q >= DimeValue);
    change_left = credit_q - (give_dime ? DimeValue : NickelValue);
  end

  // State and credit registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      credit_q      <= Zero;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Next-state and next-credit logic
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cancel && (credit_q != Zero)) begin
          // Refund takes priority; a coin arriving alongside is bounced.
          state_d       = StChange;
          coin_reject_d = any_strobe;
        end else if (coin_valid) begin
          if (credit_sum >= PriceValue) begin
            credit_d = credit_sum - PriceValue;
            state_d  = StVend;
          end else begin
            credit_d = credit_sum;
          end
        end else begin
          coin_reject_d = any_strobe;
        end
      end

      StVend: begin
        state_d       = (credit_q != Zero) ? StChange : StIdle;
        coin_reject_d = any_strobe;
      end

      StChange: begin
        credit_d      = change_left;
        state_d       = (change_left == Zero) ? StIdle : StChange;
        coin_reject_d = any_strobe;
      end

      default: begin
        // Illegal encoding: recover to IDLE keeping the credit.
        state_d       = StIdle;
        coin_reject_d = any_strobe;
      end
    endcase
  end

  // Outputs depend only on registered state and credit
  always_comb begin
    vend        = (state_q == StVend);
    dime_out    = (state_q == StChange) && give_dime;
    nickel_out  = (state_q == StChange) && !give_dime;
    busy        = (state_q == StVend) || (state_q == StChange);
    credit      = credit_q;
    state_out   = state_q;
    coin_reject = coin_reject_q;
  end

endmodule

// File: tb/tb_vending_change_fsm.sv
module tb_vending_change_fsm;

  localparam int unsigned PRICE    = 15;
  localparam int unsigned CREDIT_W = 6;

  // Reference-model pulse codes
  localparam int KV = 1;
  localparam int KD = 2;
  localparam int KN = 3;

`ifdef VEND_QUARTER_EN
  localparam bit QOK = 1'b1;
`else
  localparam bit QOK = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                nickel, dime, quarter, cancel;
  logic                vend, dime_out, nickel_out, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state_out;

  vending_change_fsm #(
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .cancel      (cancel),
    .vend        (vend),
    .dime_out    (dime_out),
    .nickel_out  (nickel_out),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit),
    .state_out   (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: credit in cents plus a queue of the output pulses still
  // to come; the queue front is what the DUT should show this cycle.
  int m_credit;
  int m_q[$];
  bit m_rej;

  task automatic model_reset();
    m_credit = 0;
    m_q.delete();
    m_rej = 1'b0;
  endtask

  task automatic push_change();
    for (int i = 0; i < m_credit / 10; i++) m_q.push_back(KD);
    if (m_credit % 10 != 0) m_q.push_back(KN);
  endtask

  task automatic model_step(input bit n, input bit d, input bit q, input bit c);
    int strobes;
    int v;
    int p;
    bit valid;
    strobes = int'(n) + int'(d) + int'(q);
    valid   = (strobes == 1) && (!q || QOK);
    v       = n ? 5 : (d ? 10 : 25);
    if (m_q.size() > 0) begin
      p = m_q.pop_front();
      if (p == KD) m_credit -= 10;
      if (p == KN) m_credit -= 5;
      m_rej = (strobes > 0);
    end else if (c && m_credit > 0) begin
      m_rej = (strobes > 0);
      push_change();
    end else if (valid) begin
      m_rej = 1'b0;
      if (m_credit + v >= int'(PRICE)) begin
        m_credit = m_credit + v - int'(PRICE);
        m_q.push_back(KV);
        push_change();
      end else begin
        m_credit += v;
      end
    end else begin
      m_rej = (strobes > 0);
    end
  endtask

  task automatic check_model(input string tag);
    int f;
    f = (m_q.size() > 0) ? m_q[0] : 0;
    chk({tag, ".vend"},        int'(vend),        int'(f == KV));
    chk({tag, ".dime_out"},    int'(dime_out),    int'(f == KD));
    chk({tag, ".nickel_out"},  int'(nickel_out),  int'(f == KN));
    chk({tag, ".busy"},        int'(busy),        int'(m_q.size() > 0));
    chk({tag, ".state_out"},   int'(state_out),   (f == 0) ? 0 : ((f == KV) ? 1 : 2));
    chk({tag, ".credit"},      int'(credit),      m_credit);
    chk({tag, ".coin_reject"}, int'(coin_reject), int'(m_rej));
  endtask

  // Drive at negedge, clock, step model, sample at the following negedge.
  task automatic cycle(input bit n, input bit d, input bit q, input bit c,
                       input bit use_model, input string tag);
    nickel  = n;
    dime    = d;
    quarter = q;
    cancel  = c;
    @(posedge clk);
    model_step(n, d, q, c);
    @(negedge clk);
    nickel  = 1'b0;
    dime    = 1'b0;
    quarter = 1'b0;
    cancel  = 1'b0;
    if (use_model) check_model(tag);
  endtask

  typedef struct {
    bit n, d, q, c;
    bit vend, dout, nout, rej, busy;
    int st;
    int cr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1,0,0,0, 0,0,0,0,0, 0, 5};   // nickel -> 5
    vecs[1]  = '{0,1,0,0, 1,0,0,0,1, 1, 0};   // dime -> exact pay, vend
    vecs[2]  = '{0,0,0,0, 0,0,0,0,0, 0, 0};   // back to idle
    vecs[3]  = '{0,1,0,0, 0,0,0,0,0, 0, 10};  // dime -> 10
    vecs[4]  = '{0,1,0,0, 1,0,0,0,1, 1, 5};   // dime -> 20, vend, 5 change
    vecs[5]  = '{1,0,0,0, 0,0,1,1,1, 2, 5};   // coin in VEND rejected; nickel out
    vecs[6]  = '{0,0,0,0, 0,0,0,0,0, 0, 0};   // idle, credit 0
    vecs[7]  = '{1,1,0,0, 0,0,0,1,0, 0, 0};   // two strobes rejected
    vecs[8]  = '{0,0,0,1, 0,0,0,0,0, 0, 0};   // cancel at 0: no effect
    vecs[9]  = '{1,0,0,0, 0,0,0,0,0, 0, 5};
    vecs[10] = '{1,0,0,0, 0,0,0,0,0, 0, 10};
    vecs[11] = '{0,1,0,1, 0,1,0,1,1, 2, 10};  // cancel + dime: refund, dime rejected
    vecs[12] = '{0,0,0,0, 0,0,0,0,0, 0, 0};

    nickel  = 1'b0;
    dime    = 1'b0;
    quarter = 1'b0;
    cancel  = 1'b0;
    reset   = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.vend",        int'(vend),        0);
    chk("rst.dime_out",    int'(dime_out),    0);
    chk("rst.nickel_out",  int'(nickel_out),  0);
    chk("rst.coin_reject", int'(coin_reject), 0);
    chk("rst.busy",        int'(busy),        0);
    chk("rst.credit",      int'(credit),      0);
    chk("rst.state_out",   int'(state_out),   0);
    reset = 1'b0;

    // Table-driven directed vectors
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].c, 1'b0, "tbl");
      chk($sformatf("tbl%0d.vend", i),        int'(vend),        int'(vecs[i].vend));
      chk($sformatf("tbl%0d.dime_out", i),    int'(dime_out),    int'(vecs[i].dout));
      chk($sformatf("tbl%0d.nickel_out", i),  int'(nickel_out),  int'(vecs[i].nout));
      chk($sformatf("tbl%0d.coin_reject", i), int'(coin_reject), int'(vecs[i].rej));
      chk($sformatf("tbl%0d.busy", i),        int'(busy),        int'(vecs[i].busy));
      chk($sformatf("tbl%0d.state_out", i),   int'(state_out),   vecs[i].st);
      chk($sformatf("tbl%0d.credit", i),      int'(credit),      vecs[i].cr);
    end

    // Quarter handling
`ifdef VEND_QUARTER_EN
    cycle(0, 1, 0, 0, 1'b1, "q.dime");
    cycle(0, 0, 1, 0, 1'b1, "q.quarter");
    chk("q.vend_now", int'(vend), 1);
    chk("q.change_credit", int'(credit), 20);
    cycle(0, 0, 0, 0, 1'b1, "q.c1");
    chk("q.dime1", int'(dime_out), 1);
    cycle(0, 0, 0, 0, 1'b1, "q.c2");
    chk("q.dime2", int'(dime_out), 1);
    cycle(0, 0, 0, 0, 1'b1, "q.idle");
    chk("q.busy_low", int'(busy), 0);
`else
    cycle(1, 0, 0, 0, 1'b1, "q.nickel");
    cycle(0, 0, 1, 0, 1'b1, "q.reject");
    chk("q.reject_pulse", int'(coin_reject), 1);
    chk("q.credit_kept", int'(credit), 5);
    cycle(0, 0, 0, 1, 1'b1, "q.cancel");
    cycle(0, 0, 0, 0, 1'b1, "q.idle");
`endif

    // Asynchronous reset in the middle of CHANGE
    cycle(0, 1, 0, 0, 1'b1, "r.d1");
    cycle(0, 1, 0, 0, 1'b1, "r.d2");
    cycle(0, 0, 0, 0, 1'b1, "r.chg");
    chk("r.in_change", int'(state_out), 2);
    #2 reset = 1'b1;
    #1;
    chk("r.async.vend",       int'(vend),       0);
    chk("r.async.nickel_out", int'(nickel_out), 0);
    chk("r.async.dime_out",   int'(dime_out),   0);
    chk("r.async.busy",       int'(busy),       0);
    chk("r.async.state_out",  int'(state_out),  0);
    chk("r.async.credit",     int'(credit),     0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1'b1, "r.after");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 1'b1, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
